regfile_read_unit: RTL and testbench

//   32-entry register file with one write port and two registered read ports; the read side
//   of the processor's enabled-DFF register storage. Feeds operands to execute stage with
//   1-cycle read latency, same-cycle write->read bypass, pipeline stall hold, valid flag.

---
 rtl/regfile_read_unit.sv | 103 ++++++++++
 tb/tb_regfile_read_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/regfile_read_unit.sv
// Register file read unit: 32 x DATA_WIDTH storage, one write port, two registered read ports.
// Latency: 1 cycle from an accepted read request (rd_req=1, stall=0) to data_readRegA/B and rd_valid.
// Backpressure: stall=1 freezes read outputs and rd_valid, and drops rd_req. Writes are never blocked.
//
// Ports:
//   clock, clear                        rising-edge clock, asynchronous active-high reset
//   ctrl_writeEnable/writeReg, data_writeReg   write strobe, index, data (index 0 ignored)
//   rd_req, stall                       read request and pipeline hold
//   ctrl_readRegA/B                     read indices, sampled only on the accepting edge
//   data_readRegA/B, rd_valid           registered read data and its valid flag
module regfile_read_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  ctrl_writeEnable,
  input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
  input  logic [DATA_WIDTH-1:0] data_writeReg,
  input  logic                  rd_req,
  input  logic                  stall,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
  output logic [DATA_WIDTH-1:0] data_readRegA,
  output logic [DATA_WIDTH-1:0] data_readRegB,
  output logic                  rd_valid
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  logic [DATA_WIDTH-1:0] rd_a_q, rd_a_d;
  logic [DATA_WIDTH-1:0] rd_b_q, rd_b_d;
  logic                  rd_valid_q, rd_valid_d;

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] sel_a, sel_b;

  // Index 0 is never written, so entry 0 stays at its reset value of zero.
  assign wr_en = ctrl_writeEnable && (ctrl_writeReg != '0);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[ctrl_writeReg] <= data_writeReg;
    end
  end

  // Read selection: index 0 forces zero; a same-edge write to the same nonzero
  // index is forwarded so the consumer sees the new value rather than the old.
  always_comb begin
    sel_a = regs_q[ctrl_readRegA];
    if (ctrl_readRegA == '0) begin
      sel_a = '0;
    end else if (wr_en && (ctrl_readRegA == ctrl_writeReg)) begin
      sel_a = data_writeReg;
    end
  end

  always_comb begin
    sel_b = regs_q[ctrl_readRegB];
    if (ctrl_readRegB == '0) begin
      sel_b = '0;
    end else if (wr_en && (ctrl_readRegB == ctrl_writeReg)) begin
      sel_b = data_writeReg;
    end
  end

  // Stall has priority: outputs and valid hold, and the request is dropped.
  // Idle edges clear valid but keep the last data visible.
  always_comb begin
    rd_a_d     = rd_a_q;
    rd_b_d     = rd_b_q;
    rd_valid_d = rd_valid_q;
    if (!stall) begin
      rd_valid_d = rd_req;
      if (rd_req) begin
        rd_a_d = sel_a;
        rd_b_d = sel_b;
      end
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      rd_a_q     <= '0;
      rd_b_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_a_q     <= rd_a_d;
      rd_b_q     <= rd_b_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign data_readRegA = rd_a_q;
  assign data_readRegB = rd_b_q;
  assign rd_valid      = rd_valid_q;

endmodule

// File: tb/tb_regfile_read_unit.sv
module tb_regfile_read_unit;

  logic        clock = 1'b0;
  logic        clear;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic        rd_req;
  logic        stall;
  logic [4:0]  ctrl_readRegA;
  logic [4:0]  ctrl_readRegB;
  logic [31:0] data_readRegA;
  logic [31:0] data_readRegB;
  logic        rd_valid;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_read_unit #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5),
    .NUM_REGS  (32)
  ) dut (
    .clock           (clock),
    .clear           (clear),
    .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg   (ctrl_writeReg),
    .data_writeReg   (data_writeReg),
    .rd_req          (rd_req),
    .stall           (stall),
    .ctrl_readRegA   (ctrl_readRegA),
    .ctrl_readRegB   (ctrl_readRegB),
    .data_readRegA   (data_readRegA),
    .data_readRegB   (data_readRegB),
    .rd_valid        (rd_valid)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One rising edge, then settle 1ns so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_wr(input logic en, input logic [4:0] idx, input logic [31:0] dat);
    ctrl_writeEnable = en;
    ctrl_writeReg    = idx;
    data_writeReg    = dat;
  endtask

  task automatic set_rd(input logic req, input logic stl, input logic [4:0] a, input logic [4:0] b);
    rd_req        = req;
    stall         = stl;
    ctrl_readRegA = a;
    ctrl_readRegB = b;
  endtask

  initial begin
    clear = 1'b1;
    set_wr(1'b0, 5'd0, 32'h0);
    set_rd(1'b0, 1'b0, 5'd0, 5'd0);
    #12;
    check("reset_a", data_readRegA, 32'h0);
    check("reset_b", data_readRegB, 32'h0);
    check("reset_vld", {31'b0, rd_valid}, 32'h0);
    clear = 1'b0;

    // 1. Clear mid-cycle after writes and a valid read.
    set_wr(1'b1, 5'd5, 32'hAAAA5555);
    step();
    set_wr(1'b0, 5'd0, 32'h0);
    set_rd(1'b1, 1'b0, 5'd5, 5'd5);
    step();
    check("pre_clr_a", data_readRegA, 32'hAAAA5555);
    check("pre_clr_vld", {31'b0, rd_valid}, 32'h1);
    set_rd(1'b0, 1'b0, 5'd0, 5'd0);
    #3;
    clear = 1'b1;
    #1;
    check("clr_a", data_readRegA, 32'h0);
    check("clr_b", data_readRegB, 32'h0);
    check("clr_vld", {31'b0, rd_valid}, 32'h0);
    #2;
    clear = 1'b0;
    set_rd(1'b1, 1'b0, 5'd5, 5'd0);
    step();
    check("post_clr_r5", data_readRegA, 32'h0);
    check("post_clr_vld", {31'b0, rd_valid}, 32'h1);

    // 2. Write then read on the following edge.
    set_rd(1'b0, 1'b0, 5'd0, 5'd0);
    set_wr(1'b1, 5'd3, 32'hDEADBEEF);
    step();
    set_wr(1'b0, 5'd0, 32'h0);
    set_rd(1'b1, 1'b0, 5'd3, 5'd0);
    step();
    check("r3_a", data_readRegA, 32'hDEADBEEF);
    check("r0_b", data_readRegB, 32'h0);
    check("r3_vld", {31'b0, rd_valid}, 32'h1);

    // 3. Same-edge write and read of reg7 on both ports.
    set_wr(1'b1, 5'd7, 32'h12345678);
    set_rd(1'b1, 1'b0, 5'd7, 5'd7);
    step();
    check("byp_a", data_readRegA, 32'h12345678);
    check("byp_b", data_readRegB, 32'h12345678);

    // 4. Writes to reg0 are ignored, including same-edge bypass.
    set_wr(1'b1, 5'd0, 32'hFFFFFFFF);
    set_rd(1'b0, 1'b0, 5'd0, 5'd0);
    step();
    set_wr(1'b0, 5'd0, 32'h0);
    set_rd(1'b1, 1'b0, 5'd0, 5'd0);
    step();
    check("r0_after_wr", data_readRegA, 32'h0);
    set_wr(1'b1, 5'd0, 32'hFFFFFFFF);
    set_rd(1'b1, 1'b0, 5'd0, 5'd3);
    step();
    check("r0_same_edge", data_readRegA, 32'h0);
    check("r3_port_b", data_readRegB, 32'hDEADBEEF);

    // 5. Stall holds outputs for 3 cycles; a write during stall still lands.
    set_wr(1'b0, 5'd0, 32'h0);
    set_rd(1'b1, 1'b0, 5'd3, 5'd3);
    step();
    check("pre_stall_a", data_readRegA, 32'hDEADBEEF);
    set_rd(1'b1, 1'b1, 5'd7, 5'd7);
    set_wr(1'b1, 5'd9, 32'h0BADF00D);
    for (int i = 0; i < 3; i++) begin
      step();
      set_wr(1'b0, 5'd0, 32'h0);
      check($sformatf("stall%0d_a", i), data_readRegA, 32'hDEADBEEF);
      check($sformatf("stall%0d_b", i), data_readRegB, 32'hDEADBEEF);
      check($sformatf("stall%0d_vld", i), {31'b0, rd_valid}, 32'h1);
    end
    set_rd(1'b1, 1'b0, 5'd7, 5'd9);
    step();
    check("unstall_a", data_readRegA, 32'h12345678);
    check("unstall_b", data_readRegB, 32'h0BADF00D);

    // 6. Idle edge drops valid, keeps data.
    set_rd(1'b0, 1'b0, 5'd3, 5'd3);
    step();
    check("idle_vld", {31'b0, rd_valid}, 32'h0);
    check("idle_a", data_readRegA, 32'h12345678);
    check("idle_b", data_readRegB, 32'h0BADF00D);

    // Stall with no request keeps valid low.
    set_rd(1'b1, 1'b1, 5'd3, 5'd3);
    step();
    check("stall_idle_vld", {31'b0, rd_valid}, 32'h0);
    check("stall_idle_a", data_readRegA, 32'h12345678);

    // Bypass applies per port: only port A matches the write index.
    set_wr(1'b1, 5'd3, 32'hCAFEBABE);
    set_rd(1'b1, 1'b0, 5'd3, 5'd7);
    step();
    check("byp_only_a", data_readRegA, 32'hCAFEBABE);
    check("no_byp_b", data_readRegB, 32'h12345678);
    set_wr(1'b0, 5'd0, 32'h0);
    set_rd(1'b1, 1'b0, 5'd9, 5'd3);
    step();
    check("r9_a", data_readRegA, 32'h0BADF00D);
    check("r3_new_b", data_readRegB, 32'hCAFEBABE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
